// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point subtractor datapath.
// Contents:
//   state_t        - FSM encoding IDLE, ALIGN, SUB, NORM, PACK, DONE
//   exp_max(ew)    - all-ones biased exponent for an ew-bit exponent field
//   dp_w(mw)       - datapath width {carry, hidden, mantissa, G, R, S} = mw+5
//   qnan_pat(...)  - canonical quiet NaN {0, all-ones exponent, 1, zeros}
//   inf_mag(...)   - infinity magnitude {all-ones exponent, zeros}, no sign bit
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    SUB   = 3'd2,
    NORM  = 3'd3,
    PACK  = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic int exp_max(input int ew);
    return (1 << ew) - 1;
  endfunction

  function automatic int dp_w(input int mw);
    return mw + 5;
  endfunction

  // Patterns are built 64 bits wide and narrowed by the user to its format width.
  function automatic logic [63:0] qnan_pat(input int ew, input int mw);
    logic [63:0] p;
    p = '0;
    for (int i = mw; i < mw + ew; i++) p[i] = 1'b1;
    p[mw-1] = 1'b1;
    return p;
  endfunction

  function automatic logic [63:0] inf_mag(input int ew, input int mw);
    logic [63:0] p;
    p = '0;
    for (int i = mw; i < mw + ew; i++) p[i] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/fp_hizala_kaydirici.sv
// Alignment right shifter with sticky collection.
// Shifts the smaller operand's mantissa field {hidden, mantissa, G, R, S}
// right by the exponent difference; every bit shifted out is ORed into the
// LSB (sticky). A shift of W-1 or more leaves only the sticky bit.
// Ports:
//   din   [W-1:0]    mantissa field to align
//   shamt [SH_W-1:0] exponent difference (unsigned)
//   dout  [W-1:0]    aligned field with sticky in bit 0
module fp_hizala_kaydirici #(
  parameter int W    = 27,
  parameter int SH_W = 8
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] shamt,
  output logic [W-1:0]    dout
);

  logic [W-1:0] lost_mask;
  logic         sticky;

  always_comb begin
    lost_mask = '0;
    sticky    = 1'b0;
    dout      = '0;
    if (32'(shamt) >= 32'(W - 1)) begin
      dout = {{(W-1){1'b0}}, |din};
    end else begin
      lost_mask = ~({W{1'b1}} << shamt);
      sticky    = |(din & lost_mask);
      dout      = din >> shamt;
      dout[0]   = dout[0] | sticky;
    end
  end

endmodule

// File: rtl/fp_cikarma.sv
// Multi-cycle IEEE-754 subtractor: fark_o = g1_i - g2_i.
// Subnormal inputs are flushed to signed zero; results that underflow are
// flushed to signed zero and results that overflow become signed infinity.
// Build option: define FP_CIKARMA_RNE_EN for round-to-nearest-even in PACK;
// otherwise the result is truncated (round toward zero).
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset, drops any operation in flight
//   valid_i  operands valid (taken only when ready_o is high)
//   ready_o  high only in IDLE
//   g1_i     minuend
//   g2_i     subtrahend
//   valid_o  result valid, held until ready_i
//   ready_i  downstream accepts result
//   fark_o   difference
module fp_cikarma #(
  parameter int b = 32,
  parameter int e = 8,
  parameter int m = 23
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [b-1:0] g1_i,
  input  logic [b-1:0] g2_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [b-1:0] fark_o
);

  import fp_pkg::*;

  localparam int DW = dp_w(m);   // {carry, hidden, m, G, R, S}
  localparam int MW = DW - 1;    // {hidden, m, G, R, S}
  localparam int XW = e + 2;     // signed exponent with head-room both ways
  localparam logic [e-1:0]          EXP_ONES = '1;
  localparam logic signed [XW-1:0]  EMAX_X   = XW'(exp_max(e));
  localparam logic signed [XW-1:0]  ZERO_X   = '0;
  localparam logic signed [XW-1:0]  ONE_X    = XW'(1);
  localparam logic [b-1:0]          QNAN     = b'(qnan_pat(e, m));
  localparam logic [b-2:0]          INF_M    = (b-1)'(inf_mag(e, m));

  state_t state_q, state_d;

  logic [b-1:0]           op1_q, op2_q;
  logic                   sgn_q, eff_sub_q;
  logic signed [XW-1:0]   exp_q;
  logic [MW-1:0]          ma_q, mb_q, mnt_q;
  logic [b-1:0]           fark_q;

  // ALIGN: operand decode, special cases and magnitude ordering
  logic         s1, s2;
  logic [e-1:0] e1, e2, ea, eb;
  logic [m-1:0] f1, f2, fz1, fz2, fa, fb;
  logic         nan1, nan2, inf1, inf2, g1_big;
  logic         sp_hit;
  logic [b-1:0] sp_val;
  logic [MW-1:0] mb_in, mb_al;

  assign s1  = op1_q[b-1];
  assign s2  = op2_q[b-1];
  assign e1  = op1_q[b-2:m];
  assign e2  = op2_q[b-2:m];
  assign f1  = op1_q[m-1:0];
  assign f2  = op2_q[m-1:0];
  assign nan1 = (e1 == EXP_ONES) && (f1 != '0);
  assign nan2 = (e2 == EXP_ONES) && (f2 != '0);
  assign inf1 = (e1 == EXP_ONES) && (f1 == '0);
  assign inf2 = (e2 == EXP_ONES) && (f2 == '0);
  // Subnormals carry exponent 0; dropping the fraction makes them signed zero.
  assign fz1 = (e1 == '0) ? '0 : f1;
  assign fz2 = (e2 == '0) ? '0 : f2;
  assign g1_big = {e1, fz1} >= {e2, fz2};
  assign ea = g1_big ? e1 : e2;
  assign eb = g1_big ? e2 : e1;
  assign fa = g1_big ? fz1 : fz2;
  assign fb = g1_big ? fz2 : fz1;
  assign mb_in = {(eb != '0), fb, 3'b000};

  always_comb begin
    sp_hit = 1'b1;
    sp_val = QNAN;
    if (nan1 || nan2)       sp_val = QNAN;
    else if (inf1 && inf2)  sp_val = (s1 == s2) ? QNAN : {s1, INF_M};
    else if (inf1)          sp_val = {s1, INF_M};
    else if (inf2)          sp_val = {~s2, INF_M};
    else                    sp_hit = 1'b0;
  end

  fp_hizala_kaydirici #(
    .W   (MW),
    .SH_W(e)
  ) u_hizala (
    .din  (mb_in),
    .shamt(ea - eb),
    .dout (mb_al)
  );

  // SUB: |A| >= |B| keeps the effective subtraction non-negative
  logic [DW-1:0] sum;
  logic [MW-1:0] sub_mnt;

  always_comb begin
    sum     = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                        : ({1'b0, ma_q} + {1'b0, mb_q});
    sub_mnt = sum[DW-1] ? {sum[DW-1:2], sum[1] | sum[0]} : sum[MW-1:0];
  end

  // NORM: one left shift per cycle until the hidden position is set
  logic norm_done;
  assign norm_done = mnt_q[MW-1] || (mnt_q == '0);

  // PACK: rounding and range handling
  logic [m-1:0]         frac_t, frac_p;
  logic signed [XW-1:0] exp_r;
  logic [b-1:0]         pack_val;

  always_comb begin
    frac_t = mnt_q[MW-2:3];
    frac_p = frac_t;
    exp_r  = exp_q;
`ifdef FP_CIKARMA_RNE_EN
    if (mnt_q[2] && (mnt_q[1] || mnt_q[0] || frac_t[0])) begin
      if (&frac_t) begin
        frac_p = '0;
        exp_r  = exp_q + ONE_X;
      end else begin
        frac_p = frac_t + m'(1);
      end
    end
`endif
    if (mnt_q == '0)          pack_val = '0;
    else if (exp_r <= ZERO_X) pack_val = {sgn_q, {(b-1){1'b0}}};
    else if (exp_r >= EMAX_X) pack_val = {sgn_q, INF_M};
    else                      pack_val = {sgn_q, exp_r[e-1:0], frac_p};
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = ALIGN;
      end
      ALIGN: state_d = sp_hit ? DONE : SUB;
      SUB:   state_d = NORM;
      NORM:  if (norm_done) state_d = PACK;
      PACK:  state_d = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers, advanced per FSM state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op1_q     <= '0;
      op2_q     <= '0;
      sgn_q     <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      mnt_q     <= '0;
      fark_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            op1_q <= g1_i;
            op2_q <= g2_i;
          end
        end
        ALIGN: begin
          if (sp_hit) begin
            fark_q <= sp_val;
          end else begin
            sgn_q     <= g1_big ? s1 : ~s2;
            eff_sub_q <= (s1 == s2);
            exp_q     <= $signed({2'b00, ea});
            ma_q      <= {(ea != '0), fa, 3'b000};
            mb_q      <= mb_al;
          end
        end
        SUB: begin
          mnt_q <= sub_mnt;
          if (sum[DW-1]) exp_q <= exp_q + ONE_X;
        end
        NORM: begin
          if (!norm_done) begin
            mnt_q <= {mnt_q[MW-2:0], 1'b0};
            exp_q <= exp_q - ONE_X;
          end
        end
        PACK: fark_q <= pack_val;
        default: ;
      endcase
    end
  end

  assign fark_o = fark_q;

endmodule

// File: tb/tb_fp_cikarma.sv
// Scoreboard bench for fp_cikarma (binary32). Expected result and latency are
// pushed when an operation is driven and popped when valid_o appears.
module tb_fp_cikarma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o, valid_o, ready_i;
  logic [31:0] g1, g2, fark;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [7:0]  lat;
  } sb_t;

  sb_t sb[$];

  fp_cikarma #(.b(32), .e(8), .m(23)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .g1_i   (g1),
    .g2_i   (g2),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .fark_o (fark)
  );

  always #5 clk = ~clk;

  // Drive one operation, measure edges from the accepting edge to valid_o,
  // capture fark_o, then release it with a one-cycle ready_i pulse.
  task automatic do_op(input logic [31:0] a, input logic [31:0] bb,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    g1 = a; g2 = bb; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (valid_o) begin
        lat = n;
        res = fark;
        break;
      end
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  task automatic run_table(input string name, input sb_t tbl[]);
    sb_t v;
    logic [31:0] r;
    int l;
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      do_op(tbl[i].a, tbl[i].b, r, l);
      v = sb.pop_front();
      total++;
      if (r !== v.res) begin
        bad++;
        $display("FAIL %s[%0d] result %h-%h: got %h want %h", name, i, v.a, v.b, r, v.res);
      end
      total++;
      if (l !== int'(v.lat)) begin
        bad++;
        $display("FAIL %s[%0d] latency %h-%h: got %0d want %0d", name, i, v.a, v.b, l, v.lat);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; g1 = '0; g2 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset valid_o: got %b want 0", valid_o); end
    total++; if (fark !== 32'h0) begin bad++; $display("FAIL reset fark_o: got %h want 0", fark); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset ready_o: got %b want 1", ready_o); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_normal();
    sb_t tbl[] = '{
      '{32'h40400000, 32'h3F800000, 32'h40000000, 8'd4},  // 3-1
      '{32'h3F800000, 32'h3F400000, 32'h3E800000, 8'd6},  // 1-0.75, k=2
      '{32'h3F800000, 32'hBF800000, 32'h40000000, 8'd4},  // carry path
      '{32'h40A00000, 32'h40A00000, 32'h00000000, 8'd4},  // exact zero
      '{32'h40000000, 32'h40400000, 32'hBF800000, 8'd5},  // 2-3 swap, k=1
      '{32'hBF800000, 32'h3F800000, 32'hC0000000, 8'd4}   // -1-1
    };
    run_table("normal", tbl);
  endtask

  task automatic test_special();
    sb_t tbl[] = '{
      '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 8'd1},  // Inf-Inf
      '{32'h7F800000, 32'h3F800000, 32'h7F800000, 8'd1},  // Inf-1
      '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 8'd1},  // NaN
      '{32'hFF800000, 32'h7F800000, 32'hFF800000, 8'd1},  // -Inf-Inf
      '{32'h3F800000, 32'h7F800000, 32'hFF800000, 8'd1}   // 1-Inf
    };
    run_table("special", tbl);
  endtask

  task automatic test_range();
    sb_t tbl[] = '{
      '{32'h00000001, 32'h00000000, 32'h00000000, 8'd4},  // subnormal flush
      '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 8'd4},  // overflow to Inf
      '{32'h00800000, 32'h00C00000, 32'h80000000, 8'd5}   // underflow flush
    };
    run_table("range", tbl);
  endtask

  task automatic test_rounding();
    sb_t tbl[] = '{
`ifdef FP_CIKARMA_RNE_EN
      '{32'h3F800000, 32'h30800000, 32'h3F800000, 8'd5}
`else
      '{32'h3F800000, 32'h30800000, 32'h3F7FFFFF, 8'd5}
`endif
    };
    run_table("round", tbl);
  endtask

  task automatic test_backpressure();
    sb_t v;
    int seen;
    sb.push_back('{32'h40400000, 32'h3F800000, 32'h40000000, 8'd4});
    @(negedge clk);
    g1 = 32'h40400000; g2 = 32'h3F800000; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk); #1;
    g1 = 32'h3F800000; g2 = 32'h3F400000;  // kept valid: must be ignored while busy
    seen = 0;
    for (int n = 0; n < 50 && seen == 0; n++) begin
      @(posedge clk); #1;
      if (valid_o) seen = 1;
    end
    v = sb.pop_front();
    total++; if (seen != 1) begin bad++; $display("FAIL bp timeout: got valid_o=%b want 1", valid_o); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (fark !== v.res) begin bad++; $display("FAIL bp fark_o cyc%0d: got %h want %h", c, fark, v.res); end
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL bp valid_o cyc%0d: got %b want 1", c, valid_o); end
      total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp ready_o cyc%0d: got %b want 0", c, ready_o); end
    end
    @(negedge clk); valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL bp release valid_o: got %b want 0", valid_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL bp release ready_o: got %b want 1", ready_o); end
  endtask

  task automatic test_reset_mid();
    sb_t tbl[] = '{'{32'h40000000, 32'h40400000, 32'hBF800000, 8'd5}};
    @(negedge clk);
    g1 = 32'h3F800000; g2 = 32'h3F400000; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);   // now in NORM
    #2;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL midrst busy ready_o: got %b want 0", ready_o); end
    rst_n = 1'b0;
    #1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL midrst valid_o: got %b want 0", valid_o); end
    total++; if (fark !== 32'h0) begin bad++; $display("FAIL midrst fark_o: got %h want 0", fark); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL midrst ready_o: got %b want 1", ready_o); end
    @(negedge clk); rst_n = 1'b1;
    run_table("after_rst", tbl);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_rounding();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_cikarma.md
Name: fp_cikarma

Overview:
- Multi-cycle IEEE-754 floating-point subtractor: fark_o = g1_i − g2_i.
- Companion to the team's fp adder. It covers the opposite arithmetic direction, with correct sign-magnitude handling, normalization and special cases.
- Sits in the same FP datapath. Uses a valid/ready handshake on both sides.

Parameters:
b, 32, total width (16/32/64)
e, 8, exponent width (5/8/11)
m, 23, mantissa width (10/23/52)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  operands valid
ready_o  output  1  block can accept operands (high only in IDLE)
g1_i  input  b  minuend
g2_i  input  b  subtrahend
valid_o  output  1  fark_o valid; held until ready_i
ready_i  input  1  downstream accepts result
fark_o  output  b  difference

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset (any time, including mid-operation): state=IDLE, valid_o=0, fark_o=0, ready_o=1, all internal registers cleared. Any in-flight operation is dropped.
- Accept: valid_i && ready_o at a rising edge; operands are registered, state goes to ALIGN.
- Operand treatment:
  - Subnormal operands are flushed to signed zero.
  - Exponent all-ones is Inf or NaN.
- ALIGN:
  - Special cases go directly to DONE:
    - NaN operand → 0x7FC00000-style canonical qNaN {0, all-ones exponent, 1, zeros}.
    - Inf−Inf with same sign → qNaN.
    - Either operand Inf → that Inf, with sign flipped if it comes from g2.
  - Otherwise, swap so the larger magnitude is A. Result sign = sign(g1) if |g1|≥|g2|, else ~sign(g2).
  - Shift B's mantissa right by the exponent difference into an (m+4)-bit field {hidden, m, G, R, S}. S is the OR of shifted-out bits. A shift ≥ m+3 leaves B as sticky only.
- SUB:
  - Same operand signs → effective subtract: A−B.
  - Different signs → effective add.
  - Carry-out → shift right 1 (sticky preserved), exponent+1.
- NORM:
  - Each cycle, if MSB=0 and the mantissa is nonzero: shift left 1, exponent−1.
  - Go to PACK when MSB=1 or the result is zero.
  - k = number of left shifts (0..m+3).
- PACK:
  - Round by truncation, unless FP_CIKARMA_RNE_EN.
  - Zero magnitude → +0.
  - Exponent ≤ 0 → signed zero (flush).
  - Exponent ≥ all-ones → signed Inf.
  - Go to DONE.
- DONE: valid_o=1, fark_o stable. On ready_i → IDLE, valid_o=0 at the same edge.
- Latency, counted in edges from the accepting edge to valid_o=1:
  - 1 for special cases.
  - 4+k for normal cases.
  - Throughput is one operation at a time; ready_o=0 from ALIGN through DONE.
- Inputs are ignored outside IDLE. valid_i during a busy period is not queued.

Optional Feature:
FP_CIKARMA_RNE_EN:
- Defined: PACK rounds to nearest-even using G,R,S. A rounding mantissa overflow sets the mantissa to 0 and increments the exponent (may produce Inf). Adds one PACK cycle only if overflow handling requires it: no, rounding completes in the same PACK cycle.
- Undefined: truncation (round toward zero); G/R/S are still kept for correct normalization.

Decomposition:
- Package fp_pkg:
  - State encoding: IDLE, ALIGN, SUB, NORM, PACK, DONE.
  - Width localparams derived from b/e/m: EXP_MAX, DP_W = m+5.
  - qNaN/Inf pattern constants.
- One sub-module, fp_hizala_kaydirici: combinational right barrel shifter with sticky OR, used in ALIGN.
- FSM, exponent arithmetic and PACK stay in fp_cikarma.

Test Plan:
- 0x40400000 − 0x3F800000 (3−1) → fark_o=0x40000000, valid_o 4 edges after accept.
- 0x3F800000 − 0x3F400000 (1−0.75) → 0x3E800000, k=2, latency 6.
- 0x3F800000 − 0xBF800000 (1−(−1)) → 0x40000000 via carry path, latency 4; 0x40A00000 − 0x40A00000 → 0x00000000.
- 0x7F800000 − 0x7F800000 → 0x7FC00000, latency 1; 0x7F800000 − 0x3F800000 → 0x7F800000.
- 0x3F800000 − 0x30800000 (1−2^-30) → 0x3F7FFFFF without FP_CIKARMA_RNE_EN, 0x3F800000 with it.
- Backpressure and reset:
  - Hold ready_i=0 for 5 cycles in DONE → fark_o and valid_o stable, ready_o=0.
  - Then ready_i=1 → IDLE next edge.
  - Drop rst_ni during NORM → outputs immediately valid_o=0, fark_o=0, ready_o=1.
